// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: loads a WIDTH-bit transmit word, shifts it out
// on launch edges while capturing WIDTH bits on sample edges, then presents the
// received word in parallel with a one-cycle done pulse.
module spi_shift_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sclk_rise,
  input  logic             i_sclk_fall,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_lsb_first,
  input  logic             i_cpha,
  input  logic             i_abort,
  input  logic             i_serial_in,
  output logic             o_serial_out,
  output logic [WIDTH-1:0] o_parallel_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_parallel_out;
  logic [CntW-1:0]  r_count;
  logic             r_lsb_first;
  logic             r_cpha;
  logic             r_serial_out;
  logic             r_done;

  logic             w_sample;
  logic             w_launch;
  logic             w_last;
  logic             w_head;
  logic             w_load_head;
  logic [WIDTH-1:0] w_shifted;

  // Edge role mapping, next shift value and head-bit selection.
  always_comb begin
    w_sample    = r_cpha ? i_sclk_fall : i_sclk_rise;
    // A coincident rise/fall is treated as a sample only; the launch is dropped.
    w_launch    = (r_cpha ? i_sclk_rise : i_sclk_fall) & ~w_sample;
    w_last      = (r_count == CntW'(WIDTH - 1));
    w_head      = r_lsb_first ? r_shreg[0] : r_shreg[WIDTH-1];
    w_load_head = i_lsb_first ? i_load_data[0] : i_load_data[WIDTH-1];
    w_shifted   = r_lsb_first ? {i_serial_in, r_shreg[WIDTH-1:1]}
                              : {r_shreg[WIDTH-2:0], i_serial_in};
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_shreg        <= '0;
      r_parallel_out <= '0;
      r_count        <= '0;
      r_lsb_first    <= 1'b0;
      r_cpha         <= 1'b0;
      r_serial_out   <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          // Abort in idle also suppresses a coincident load.
          if (i_load && !i_abort) begin
            r_shreg      <= i_load_data;
            r_count      <= '0;
            r_lsb_first  <= i_lsb_first;
            r_cpha       <= i_cpha;
            r_serial_out <= w_load_head;
            r_state      <= StShift;
          end
        end
        StShift: begin
          if (i_abort) begin
            r_state <= StIdle;
          end else if (w_sample) begin
            r_shreg <= w_shifted;
            r_count <= r_count + CntW'(1);
            if (w_last) begin
              r_parallel_out <= w_shifted;
              r_done         <= 1'b1;
              r_state        <= StIdle;
            end
          end else if (w_launch) begin
            r_serial_out <= w_head;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_serial_out   = r_serial_out;
  assign o_parallel_out = r_parallel_out;
  assign o_busy         = (r_state == StShift);
  assign o_done         = r_done;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: an 8-bit and a 16-bit instance share
// stimulus; expected values are hand-computed per test.
module tb_spi_shift_engine;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_sclk_rise;
  logic        i_sclk_fall;
  logic        i_load;
  logic [15:0] i_load_data;
  logic        i_lsb_first;
  logic        i_cpha;
  logic        i_abort;
  logic        i_serial_in;

  logic        so8, busy8, done8;
  logic [7:0]  par8;
  logic        so16, busy16, done16;
  logic [15:0] par16;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  spi_shift_engine #(.WIDTH(8)) u_dut8 (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_sclk_rise    (i_sclk_rise),
    .i_sclk_fall    (i_sclk_fall),
    .i_load         (i_load),
    .i_load_data    (i_load_data[7:0]),
    .i_lsb_first    (i_lsb_first),
    .i_cpha         (i_cpha),
    .i_abort        (i_abort),
    .i_serial_in    (i_serial_in),
    .o_serial_out   (so8),
    .o_parallel_out (par8),
    .o_busy         (busy8),
    .o_done         (done8)
  );

  spi_shift_engine #(.WIDTH(16)) u_dut16 (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_sclk_rise    (i_sclk_rise),
    .i_sclk_fall    (i_sclk_fall),
    .i_load         (i_load),
    .i_load_data    (i_load_data),
    .i_lsb_first    (i_lsb_first),
    .i_cpha         (i_cpha),
    .i_abort        (i_abort),
    .i_serial_in    (i_serial_in),
    .o_serial_out   (so16),
    .o_parallel_out (par16),
    .o_busy         (busy16),
    .o_done         (done16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply edge enables for one clock, then return to 1ns after the edge.
  task automatic step(input logic rise, input logic fall, input logic sin);
    i_sclk_rise = rise;
    i_sclk_fall = fall;
    i_serial_in = sin;
    @(posedge i_clk);
    #1;
    i_sclk_rise = 1'b0;
    i_sclk_fall = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] data, input logic lsb, input logic cpha);
    i_load      = 1'b1;
    i_load_data = data;
    i_lsb_first = lsb;
    i_cpha      = cpha;
    step(1'b0, 1'b0, 1'b0);
    i_load = 1'b0;
  endtask

  task automatic outs(input bit w16, output logic so, output logic [1:0] bd,
                      output logic [15:0] par);
    so  = w16 ? so16 : so8;
    bd  = w16 ? {busy16, done16} : {busy8, done8};
    par = w16 ? par16 : {8'h00, par8};
  endtask

  // tx/rx bit i is the i-th bit in time. poke >= 0 drives a load of 0xFF on
  // that sample; chain starts a second transfer with chain_data in the done cycle.
  task automatic xfer(input string name, input int n, input bit w16, input logic cpha,
                      input logic [15:0] tx, input logic [15:0] rx,
                      input logic [15:0] par_exp, input int poke, input bit chain,
                      input logic [15:0] chain_data);
    logic so;
    logic [1:0] bd;
    logic [15:0] par;
    for (int i = 0; i < n; i++) begin
      if (cpha) step(1'b1, 1'b0, 1'b0);
      outs(w16, so, bd, par);
      check_eq($sformatf("%s so[%0d]", name, i), {31'd0, so}, {31'd0, tx[i]});
      if (i == poke) begin
        i_load      = 1'b1;
        i_load_data = 16'hFFFF;
      end
      if (cpha) step(1'b0, 1'b1, rx[i]);
      else      step(1'b1, 1'b0, rx[i]);
      i_load = 1'b0;
      outs(w16, so, bd, par);
      check_eq($sformatf("%s busy/done[%0d]", name, i), {30'd0, bd},
               (i == n - 1) ? 32'd1 : 32'd2);
      if (i == n - 1) check_eq($sformatf("%s parallel", name), {16'd0, par}, {16'd0, par_exp});
      if (!cpha && i != n - 1) step(1'b0, 1'b1, 1'b0);
    end
    if (chain) begin
      i_load      = 1'b1;
      i_load_data = chain_data;
      step(1'b0, 1'b1, 1'b0);
      i_load = 1'b0;
      outs(w16, so, bd, par);
      check_eq($sformatf("%s chain busy", name), {30'd0, bd}, 32'd2);
    end else begin
      // Trailing cpha=0 launch lands in idle and must not move serial out.
      step(1'b0, !cpha, 1'b0);
      outs(w16, so, bd, par);
      check_eq($sformatf("%s post busy/done", name), {30'd0, bd}, 32'd0);
      check_eq($sformatf("%s post so", name), {31'd0, so}, {31'd0, tx[n-1]});
    end
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_sclk_rise = 1'b0;
    i_sclk_fall = 1'b0;
    i_load      = 1'b0;
    i_load_data = '0;
    i_lsb_first = 1'b0;
    i_cpha      = 1'b0;
    i_abort     = 1'b0;
    i_serial_in = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("reset dut8", {so8, par8, busy8, done8}, 32'd0);
    check_eq("reset dut16", {so16, par16, busy16, done16}, 32'd0);
    i_rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // MSB-first cpha=0, 0xC4: out 1,1,0,0,0,1,0,0 (0x23), in 0,0,1,1,1,1,0,0 (0x3C).
    // A busy load of 0xFF at bit 2 is ignored; lsb_first changes mid-flight
    // without effect, then an LSB-first 0xC4 transfer chains in the done cycle.
    do_load(16'h00C4, 1'b0, 1'b0);
    check_eq("load busy", {31'd0, busy8}, 32'd1);
    i_lsb_first = 1'b1;
    xfer("msb_c4", 8, 1'b0, 1'b0, 16'h0023, 16'h003C, 16'h003C, 2, 1'b1, 16'h00C4);
    // LSB-first: out 0,0,1,0,0,0,1,1 (0xC4), in 1 then zeros -> 0x01.
    xfer("lsb_c4", 8, 1'b0, 1'b0, 16'h00C4, 16'h0001, 16'h0001, -1, 1'b0, 16'h0000);

    // cpha=1 MSB-first 0xA5, serial in tied 1: out 1,0,1,0,0,1,0,1 (0xA5), in 0xFF.
    do_load(16'h00A5, 1'b0, 1'b1);
    xfer("cpha1_a5", 8, 1'b0, 1'b1, 16'h00A5, 16'h00FF, 16'h00FF, -1, 1'b0, 16'h0000);

    // Abort after 3 samples, coincident with a sample edge; parallel stays 0xFF.
    do_load(16'h005A, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    // 0x5A launched bits 0,1,0,1: serial out is 1 before the abort.
    i_abort = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    i_abort = 1'b0;
    check_eq("abort busy/done", {30'd0, busy8, done8}, 32'd0);
    check_eq("abort parallel", {24'd0, par8}, 32'h0000_00FF);
    check_eq("abort so holds", {31'd0, so8}, 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check_eq("abort no late done", {30'd0, busy8, done8}, 32'd0);

    // Abort in idle blocks a coincident load.
    i_abort     = 1'b1;
    i_load      = 1'b1;
    i_load_data = 16'h0001;
    step(1'b0, 1'b0, 1'b0);
    i_abort = 1'b0;
    i_load  = 1'b0;
    check_eq("idle abort+load", {31'd0, busy8}, 32'd0);

    // Coincident rise/fall: one sample, launch dropped (serial out stays 1 for 0x80).
    do_load(16'h0080, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_eq("dual so held", {31'd0, so8}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check_eq($sformatf("dual busy/done[%0d]", i), {30'd0, busy8, done8},
               (i == 6) ? 32'd1 : 32'd2);
      step(1'b0, 1'b1, 1'b0);
    end
    check_eq("dual parallel", {24'd0, par8}, 32'h0000_0080);

    // Asynchronous reset mid-transfer, between clock edges.
    do_load(16'h00FF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
    end
    check_eq("pre-reset so", {31'd0, so8}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check_eq("async reset dut8", {so8, par8, busy8, done8}, 32'd0);
    check_eq("async reset dut16", {so16, par16, busy16, done16}, 32'd0);
    @(posedge i_clk);
    #1;
    check_eq("reset no done", {31'd0, done8}, 32'd0);
    i_rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // WIDTH=16 MSB-first 0x8001 (palindrome order), in 0xBEEF MSB first
    // -> time-ordered vector 0xF77D.
    do_load(16'h8001, 1'b0, 1'b0);
    check_eq("w16 load busy", {31'd0, busy16}, 32'd1);
    xfer("w16", 16, 1'b1, 1'b0, 16'h8001, 16'hF77D, 16'hBEEF, -1, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised full-duplex SPI shift engine: loads a WIDTH-bit transmit word, shifts it out serially while capturing WIDTH received bits, then presents the received word in parallel with a one-cycle done pulse. It sits between the SPI serial-clock edge detectors (which supply single-cycle rise/fall enables) and the register/FSM layer, replacing the fixed 8-bit shift register. It adds width generalisation, runtime bit order and clock-phase selection, a bit counter, busy/done handshake, abort, and asynchronous reset.

## Interface
- WIDTH, 8, word length in bits (≥2); counter width is $clog2(WIDTH+1)
- clk  in  1  system clock, all state updates on rising edge
- resetN  in  1  asynchronous active-low reset
- sclkRise  in  1  one-cycle enable, serial clock rising edge
- sclkFall  in  1  one-cycle enable, serial clock falling edge
- load  in  1  start pulse; accepted only when busy=0
- loadData  in  WIDTH  transmit word, captured on accepted load
- lsbFirst  in  1  0: MSB first, 1: LSB first; sampled at load, held for transfer
- cpha  in  1  0: sample on rise, launch on fall; 1: sample on fall, launch on rise; sampled at load
- abort  in  1  return to IDLE immediately, no done
- serialIn  in  1  MISO/MOSI receive bit
- serialOut  out  1  registered transmit bit
- parallelOut  out  WIDTH  last completed received word
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer completion

## Operation
- States: IDLE, SHIFT. Reset → IDLE; serialOut=0, parallelOut=0, busy=0, done=0, shift register and counter 0.
- Sample edge = cpha ? sclkFall : sclkRise. Launch edge = the other one. Polarity mapping uses latched cpha.
- IDLE: load=1 → shreg←loadData, count←0, latch lsbFirst/cpha, serialOut←head bit of loadData (bit WIDTH-1 or bit 0), go SHIFT. Edges ignored in IDLE; serialOut holds its value.
- SHIFT, sample edge: MSB-first shreg←{shreg[WIDTH-2:0], serialIn}; LSB-first shreg←{serialIn, shreg[WIDTH-1:1]}; count←count+1.
- SHIFT, launch edge: serialOut←current head bit of shreg (MSB-first shreg[WIDTH-1], LSB-first shreg[0]). With cpha=1 the first launch re-drives bit 0 of the word (no change); with cpha=0 each launch follows its sample.
- Completion: sample edge with count=WIDTH-1 → next cycle parallelOut←final shreg, done=1, busy=0, state IDLE. Final cpha=0 launch edge arrives in IDLE and is ignored.
- sclkRise and sclkFall asserted in the same cycle: sample action only; launch is dropped.
- load while busy=1: ignored, no state change.
- abort in SHIFT: next cycle IDLE, busy=0, no done, parallelOut unchanged, serialOut holds. abort wins over a same-cycle sample edge. abort in IDLE: no effect; load in the same cycle is ignored.
- resetN low at any time, including mid-transfer: all outputs and state return to reset values asynchronously. No done is generated.

## Timing
- load accepted at edge t → busy=1 and serialOut=first bit visible after t.
- Sample edge at cycle s → shreg/count updated after s; serialOut changes only on launch edges.
- Last sample at cycle s → done=1, busy=0, parallelOut valid during cycle s+1; done low at s+2.
- load during the done cycle is accepted (busy=0), so back-to-back transfers are supported with zero idle cycles.
- busy is a registered state decode; no combinational path exists from inputs to any output.

## Test plan
- WIDTH=8, cpha=0, MSB-first, loadData=0xC4, serialIn stream 0,0,1,1,1,1,0,0 across 8 rise/fall pairs → serialOut 1,1,0,0,0,1,0,0; parallelOut=0x3C; done exactly once; busy high for the full transfer.
- WIDTH=8, LSB-first, cpha=0, loadData=0xC4, serialIn 1,0,0,0,0,0,0,0 → serialOut 0,0,1,0,0,0,1,1; parallelOut=0x01.
- cpha=1, MSB-first, loadData=0xA5, serialIn tied 1, edges starting with a rise → serialOut 1,0,1,0,0,1,0,1 updated on rises; parallelOut=0xFF; done after the 8th fall.
- Mid-transfer, after 3 samples: assert abort → busy=0 next cycle, no done, parallelOut keeps its prior value. Repeat with resetN pulled low asynchronously between clocks → all outputs 0 immediately.
- load pulse while busy with loadData=0xFF → ignored, in-flight word unaffected. load in the done cycle → a second transfer starts with no gap. Simultaneous sclkRise and sclkFall → counted as a single sample.
- WIDTH=16, MSB-first, loadData=0x8001, serialIn=0xBEEF stream → serialOut 1 then fourteen 0 then 1; parallelOut=0xBEEF after 16 samples.
